imm_buffer: RTL
===============

# imm_buffer

In-order, out-of-order-release storage for the immediates of dispatched instructions. Rename/dispatch allocates entries and writes each immediate. Issued integer and memory uops read their immediate by `irobIdx_t`. Each execution pipe releases its entry through a clear port once the operand is consumed. The block sits in the backend between dispatch and `exeBlock`: it answers the execution block's immediate read ports and consumes its immediate-clear ports.

## Interface
Parameters:
- `SIZE`, default 32: number of entries; power of two.
- `ALLOC_WIDTH`, default 4: allocation lanes per cycle; equals `RENAME_WIDTH`.
- `READPORT_NUM`, default 8: immediate read ports; 4 ALU + 2 LDU + 2 STU.
- `CLEARPORT_NUM`, default 8: release ports; equals `IMMBUFFER_CLEARPORT_NUM`.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset; synchronous, active-high.
- `i_squash_vld`, in, 1: full backend flush.
- `i_alloc_vld`, in, `ALLOC_WIDTH`: per-lane allocation request; lanes may be sparse.
- `i_alloc_imm`, in, `imm_t` ×`ALLOC_WIDTH`: immediate to store, one per lane.
- `o_alloc_rdy`, out, 1: buffer can accept a full group this cycle.
- `o_alloc_idx`, out, `irobIdx_t` ×`ALLOC_WIDTH`: index assigned to each lane.
- `i_read_idx`, in, `irobIdx_t` ×`READPORT_NUM`: read address per port.
- `o_read_data`, out, `imm_t` ×`READPORT_NUM`: stored immediate per port.
- `i_clear_vld`, in, `CLEARPORT_NUM`: per-port release request.
- `i_clear_idx`, in, `irobIdx_t` ×`CLEARPORT_NUM`: entry released by each port.

## Operation
**State**
- `imm[SIZE]` data array.
- `vld[SIZE]` valid bits.
- `head` and `tail` pointers, each `$clog2(SIZE)+1` bits; the MSB is the wrap bit.
- `used = tail - head`, modulo `2*SIZE`.
- `free = SIZE - used`.

**Ready**
- `o_alloc_rdy = (free >= ALLOC_WIDTH)`.
- Depends on registered state only; there is no combinational path from `i_alloc_vld`.

**Allocation**
- Fires when `|i_alloc_vld && o_alloc_rdy && !i_squash_vld`.
- Lane k is assigned `o_alloc_idx[k] = (tail + popcount(i_alloc_vld[k-1:0]))[low bits]`. Valid lanes are therefore compacted in lane order.
- `o_alloc_idx` is driven every cycle regardless of valid.
- At the clock edge, each valid lane writes `imm` and sets `vld` for its index.
- `tail += popcount(i_alloc_vld)`.
- All-or-nothing: no partial group is ever accepted.

**Read**
- `o_read_data[p] = imm[i_read_idx[p][low bits]]`, purely combinational.
- There is no same-cycle write-to-read forwarding.

**Clear**
- Each valid port clears `vld[i_clear_idx]` at the edge.
- Duplicate indices across ports are legal and are ORed.
- Clearing an entry whose `vld` is already 0 is illegal; the bench asserts on it.

**Head retire**
- Each cycle, `head` advances over the longest run of consecutive entries starting at `head` that have `vld == 0`.
- The run is bounded by `head != tail` and capped at `CLEARPORT_NUM` entries per cycle.

**Squash**
- Clears all `vld` bits and sets `head = tail = 0`.
- Takes priority over allocate and clear in the same cycle.
- The data array is untouched.

**Simultaneous events**
- Allocate and clear in the same cycle never target the same slot, because allocation only uses slots `head` has already passed.
- Retire uses `vld` before that edge's clears. A clear therefore becomes retirable one cycle after it lands.

## Timing
**Reset values**
- `head = tail = 0`, all `vld = 0`, all `imm = 0`.
- `o_alloc_rdy = 1`.
- `o_alloc_idx = {0,1,2,3}` when `i_alloc_vld` is all-ones.
- `o_read_data = 0`.

**Latency**
- Allocation: index returned in cycle N; data is readable from cycle N+1.
- Release:
  - clear in cycle N;
  - `vld = 0` at edge N+1;
  - `head` moves at edge N+2;
  - `free` increases from cycle N+2.
- Squash in cycle N: the buffer is empty and `o_alloc_rdy = 1` from cycle N+1.

**Boundary conditions**
- Full/empty:
  - `used == SIZE` means full: the wrap bits differ and the index bits are equal.
  - `head == tail` means empty.
- Wrap-around:
  - Index arithmetic uses the low `$clog2(SIZE)` bits.
  - A group may straddle entry `SIZE-1` → 0.
- Reset asserted mid-operation behaves as squash plus data clear.

## Structure
Shared package (`core_define.svh`):
- `irobIdx_t` and `imm_t` typedefs.
- `IMMBUFFER_SIZE`, `IMMBUFFER_READPORT_NUM` and `IMMBUFFER_CLEARPORT_NUM` constants.

Sub-module:
- One is natural: `lane_prefix_count`, a generic per-lane exclusive popcount.
- It is used for lane compaction and reusable by rename.
- The head scan stays inline as a bounded loop.

## Test plan
- **Reset, then allocate:** after reset, allocate `i_alloc_vld=4'b1111` with imms 1..4. Expect `o_alloc_idx=0..3`, `tail=4`, and next cycle `i_read_idx=2` → 3.
- **Sparse lanes:** `i_alloc_vld=4'b1010` at `tail=4`. Expect lane1 → 4, lane3 → 5, `tail=6`.
- **Fill and wrap:**
  - Allocate 8 groups of 4. Expect `o_alloc_rdy=0` with `used=32`; a 9th request leaves `tail` unchanged.
  - Clear idx 0–3. Expect `o_alloc_rdy=1` two cycles later; the next group gets idx 0–3 and the wrap bit toggles.
- **Out-of-order release:**
  - With 8 entries live, clear idx 5 then idx 1. Expect `head` to stay at 0.
  - Clear idx 0. Expect `head` to reach 2 a cycle later.
  - Clear 2–4. Expect `head` to reach 6.
- **Squash priority:** assert squash, 4 clears and a valid allocation in the same cycle. Expect next cycle `head=tail=0`, all `vld=0`, no allocation recorded.
- **Head scan cap:** 16 entries live; clear all 16 over two cycles via 8 ports each. Expect `head` to advance by at most 8 per cycle and reach 16.

Source files
------------

// File: rtl/imm_buffer_pkg.sv
// Shared immediate-buffer types and sizing constants for the backend.
// irobIdx_t addresses one buffer entry, and imm_t is one stored immediate.
package imm_buffer_pkg;

   localparam int IMMBUFFER_SIZE          = 32;
   localparam int IMMBUFFER_ALLOC_WIDTH   = 4;
   localparam int IMMBUFFER_READPORT_NUM  = 8;
   localparam int IMMBUFFER_CLEARPORT_NUM = 8;
   localparam int IMM_WIDTH               = 32;
   localparam int IROB_IDX_WIDTH          = $clog2(IMMBUFFER_SIZE);

   typedef logic [IMM_WIDTH-1:0]      imm_t;
   typedef logic [IROB_IDX_WIDTH-1:0] irobIdx_t;

endpackage

// File: rtl/imm_buffer_lane_prefix_count.sv
// Per-lane exclusive popcount. For each lane it gives the number of set lanes below it,
// and it also gives the total number of set lanes. This compacts sparse allocation groups.
module lane_prefix_count #(
   parameter int WIDTH = 4,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] lane_vld,
   output logic [CNT_W-1:0] lane_prefix [WIDTH],
   output logic [CNT_W-1:0] lane_total
);

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_lane
         logic [CNT_W-1:0] acc;
         always_comb begin
            acc = '0;
            for (int j = 0; j < gi; j++) begin
               acc = acc + CNT_W'(lane_vld[j]);
            end
         end
         assign lane_prefix[gi] = acc;
      end
   endgenerate

   assign lane_total = lane_prefix[WIDTH-1] + CNT_W'(lane_vld[WIDTH-1]);

endmodule

// File: rtl/imm_buffer.sv
// Circular immediate buffer. Entries are allocated in order and released out of order.
// The head pointer retires the leading run of released entries, up to CLEARPORT_NUM per cycle.
module imm_buffer
   import imm_buffer_pkg::*;
#(
   parameter int SIZE          = IMMBUFFER_SIZE,
   parameter int ALLOC_WIDTH   = IMMBUFFER_ALLOC_WIDTH,
   parameter int READPORT_NUM  = IMMBUFFER_READPORT_NUM,
   parameter int CLEARPORT_NUM = IMMBUFFER_CLEARPORT_NUM
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_squash_vld,
   input  logic [ALLOC_WIDTH-1:0]     i_alloc_vld,
   input  logic [IMM_WIDTH-1:0]       i_alloc_imm [ALLOC_WIDTH],
   output logic                       o_alloc_rdy,
   output logic [$clog2(SIZE)-1:0]    o_alloc_idx [ALLOC_WIDTH],
   input  logic [$clog2(SIZE)-1:0]    i_read_idx  [READPORT_NUM],
   output logic [IMM_WIDTH-1:0]       o_read_data [READPORT_NUM],
   input  logic [CLEARPORT_NUM-1:0]   i_clear_vld,
   input  logic [$clog2(SIZE)-1:0]    i_clear_idx [CLEARPORT_NUM]
);

   localparam int IDX_W = $clog2(SIZE);
   localparam int PTR_W = IDX_W + 1;
   localparam int CNT_W = $clog2(ALLOC_WIDTH + 1);

   logic [IMM_WIDTH-1:0] imm_reg [SIZE];
   logic [SIZE-1:0]      vld_reg;
   logic [SIZE-1:0]      vld_next;
   logic [PTR_W-1:0]     head_reg;
   logic [PTR_W-1:0]     head_next;
   logic [PTR_W-1:0]     tail_reg;
   logic [PTR_W-1:0]     tail_next;

   logic [PTR_W-1:0]     used_cnt;
   logic [PTR_W:0]       free_cnt;
   logic                 alloc_fire;
   logic [CNT_W-1:0]     lane_prefix [ALLOC_WIDTH];
   logic [CNT_W-1:0]     lane_total;
   logic [IDX_W-1:0]     alloc_idx [ALLOC_WIDTH];
   logic [SIZE-1:0]      alloc_mask;
   logic [SIZE-1:0]      clear_mask;
   logic [PTR_W-1:0]     scan_ptr;
   logic                 scan_stop;

   // Both pointers carry a wrap bit, so modulo 2*SIZE subtraction tells full apart from empty.
   assign used_cnt    = tail_reg - head_reg;
   assign free_cnt    = (PTR_W + 1)'(SIZE) - {1'b0, used_cnt};
   assign o_alloc_rdy = (free_cnt >= (PTR_W + 1)'(ALLOC_WIDTH));
   assign alloc_fire  = (|i_alloc_vld) && o_alloc_rdy && !i_squash_vld;

   lane_prefix_count #(
      .WIDTH (ALLOC_WIDTH),
      .CNT_W (CNT_W)
   ) u_lane_prefix (
      .lane_vld    (i_alloc_vld),
      .lane_prefix (lane_prefix),
      .lane_total  (lane_total)
   );

   genvar gi;
   generate
      for (gi = 0; gi < ALLOC_WIDTH; gi++) begin : g_alloc
         logic [PTR_W-1:0] lane_ptr;
         assign lane_ptr         = tail_reg + PTR_W'(lane_prefix[gi]);
         assign alloc_idx[gi]    = lane_ptr[IDX_W-1:0];
         assign o_alloc_idx[gi]  = alloc_idx[gi];
      end
      for (gi = 0; gi < READPORT_NUM; gi++) begin : g_read
         assign o_read_data[gi] = imm_reg[i_read_idx[gi]];
      end
   endgenerate

   always_comb begin
      alloc_mask = '0;
      for (int k = 0; k < ALLOC_WIDTH; k++) begin
         if (alloc_fire && i_alloc_vld[k]) begin
            alloc_mask[alloc_idx[k]] = 1'b1;
         end
      end
   end

   always_comb begin
      clear_mask = '0;
      for (int p = 0; p < CLEARPORT_NUM; p++) begin
         if (i_clear_vld[p]) begin
            clear_mask[i_clear_idx[p]] = 1'b1;
         end
      end
   end

   // The retire scan reads pre-edge valid bits, so a cleared entry retires one cycle after its clear.
   always_comb begin
      scan_ptr  = head_reg;
      scan_stop = 1'b0;
      for (int i = 0; i < CLEARPORT_NUM; i++) begin
         if (!scan_stop && (scan_ptr != tail_reg) && !vld_reg[scan_ptr[IDX_W-1:0]]) begin
            scan_ptr = scan_ptr + PTR_W'(1);
         end else begin
            scan_stop = 1'b1;
         end
      end
   end

   assign head_next = scan_ptr;
   assign tail_next = alloc_fire ? (tail_reg + PTR_W'(lane_total)) : tail_reg;
   assign vld_next  = (vld_reg & ~clear_mask) | alloc_mask;

   always_ff @(posedge clk) begin
      if (rst || i_squash_vld) begin
         head_reg <= '0;
         tail_reg <= '0;
         vld_reg  <= '0;
      end else begin
         head_reg <= head_next;
         tail_reg <= tail_next;
         vld_reg  <= vld_next;
      end
   end

   // A squash leaves the data array alone. Only reset clears the stored immediates.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int e = 0; e < SIZE; e++) begin
            imm_reg[e] <= '0;
         end
      end else if (alloc_fire) begin
         for (int k = 0; k < ALLOC_WIDTH; k++) begin
            if (i_alloc_vld[k]) begin
               imm_reg[alloc_idx[k]] <= i_alloc_imm[k];
            end
         end
      end
   end

endmodule
